ifetch_unit: RTL and testbench

Instruction fetch stage for the multicycle RISC-V core. It sits directly upstream of the word-addressed instruction ROM and owns the program counter. It drives the ROM address, captures the returned word into a one-entry instruction register, and hands it to decode/control with a valid/ready handshake. It also handles control-flow redirects, the halt sentinel word, and fetch-range faults.

---
 rtl/ifetch_unit.sv | 103 ++++++++++
 tb/tb_ifetch_unit.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/ifetch_unit.sv
// rtl/ifetch_unit.sv - instruction fetch stage: PC, one-entry instruction register, redirect/halt/fault handling
module ifetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h00000000,
  parameter logic [31:0] HALT_WORD  = 32'h11111111,
  parameter int          IMEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rd,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] instr_pc4,
  output logic        halted,
  output logic        fault,
  output logic [31:0] fetch_count
);

  typedef enum logic [1:0] {RUN, HALTED, FAULT_SOFT, FAULT_HARD} state_t;

  localparam logic [31:0] NOP        = 32'h00000013;
  localparam logic [31:0] IMEM_LIMIT = 32'(IMEM_WORDS);

  state_t      state_q;
  logic [31:0] pc_q;
  logic        valid_q;
  logic [31:0] instr_q;
  logic [31:0] instr_pc_q;
  logic [31:0] instr_pc4_q;
  logic        halted_q;
  logic        fault_q;
  logic [31:0] count_q;

  logic handshake;
  logic can_load;
  logic out_of_range;

  assign handshake    = valid_q && instr_ready;
  assign can_load     = (state_q == RUN) && (!valid_q || instr_ready);
  assign out_of_range = {2'b00, pc_q[31:2]} >= IMEM_LIMIT;

  assign imem_addr   = pc_q;
  assign instr_valid = valid_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign instr_pc4   = instr_pc4_q;
  assign halted      = halted_q;
  assign fault       = fault_q;
  assign fetch_count = count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= RUN;
      pc_q        <= RESET_PC;
      valid_q     <= 1'b0;
      instr_q     <= NOP;
      instr_pc_q  <= 32'h0;
      instr_pc4_q <= 32'h0;
      halted_q    <= 1'b0;
      fault_q     <= 1'b0;
      count_q     <= 32'h0;
    end else begin
      if (handshake) begin
        count_q <= count_q + 32'd1;
      end
      if (redirect_valid && (state_q != FAULT_HARD)) begin
        valid_q <= 1'b0;
        if (redirect_pc[1:0] != 2'b00) begin
          state_q  <= FAULT_HARD;
          halted_q <= 1'b0;
          fault_q  <= 1'b1;
        end else begin
          pc_q     <= redirect_pc;
          state_q  <= RUN;
          halted_q <= 1'b0;
          fault_q  <= 1'b0;
        end
      end else if (can_load) begin
        // Range is checked before the halt word: an out-of-range read returns no meaningful data.
        if (out_of_range) begin
          valid_q <= 1'b0;
          state_q <= FAULT_SOFT;
          fault_q <= 1'b1;
        end else if (imem_rd == HALT_WORD) begin
          valid_q  <= 1'b0;
          state_q  <= HALTED;
          halted_q <= 1'b1;
        end else begin
          instr_q     <= imem_rd;
          instr_pc_q  <= pc_q;
          instr_pc4_q <= pc_q + 32'd4;
          pc_q        <= pc_q + 32'd4;
          valid_q     <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// tb/tb_ifetch_unit.sv - scoreboard bench for ifetch_unit with a behavioural ROM
module tb_ifetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] imem_addr;
  logic [31:0] imem_rd;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] instr_pc4;
  logic        halted;
  logic        fault;
  logic [31:0] fetch_count;

  logic [31:0] rom [0:63];

  typedef struct packed {
    logic [31:0] w;
    logic [31:0] pc;
  } exp_t;
  exp_t q[$];

  int checks = 0;
  int failures = 0;

  ifetch_unit dut (
    .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_rd(imem_rd),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .instr_pc(instr_pc), .instr_pc4(instr_pc4), .halted(halted),
    .fault(fault), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  assign imem_rd = (imem_addr[31:8] == 24'h0) ? rom[imem_addr[7:2]] : 32'hdeadbeef;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Monitor: every accepted handshake must match the next expected fetch.
  always @(negedge clk) begin
    if (!reset && instr_valid && instr_ready) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_handshake actual_pc=%h expected=none", instr_pc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("hs_instr", instr, e.w);
        chk("hs_pc", instr_pc, e.pc);
        chk("hs_pc4", instr_pc4, e.pc + 32'd4);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] pc);
    exp_t e;
    e.w  = rom[pc[7:2]];
    e.pc = pc;
    q.push_back(e);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    redirect_valid = 1'b0;
    #1;
    chk("rst_valid", instr_valid, 32'd0);
    chk("rst_instr", instr, 32'h00000013);
    chk("rst_pc", instr_pc, 32'h0);
    chk("rst_pc4", instr_pc4, 32'h0);
    chk("rst_halted", halted, 32'd0);
    chk("rst_fault", fault, 32'd0);
    chk("rst_count", fetch_count, 32'h0);
    chk("rst_addr", imem_addr, 32'h0);
    @(posedge clk);
    #2;
    reset = 1'b0;
  endtask

  task automatic redirect(input logic [31:0] target);
    redirect_valid = 1'b1;
    redirect_pc = target;
    step(1);
    redirect_valid = 1'b0;
  endtask

  initial begin
    int n;
    rom[0] = 32'h00c00513;
    rom[1] = 32'h008000ef;
    rom[2] = 32'h00a02023;
    rom[3] = 32'h11111111;
    for (int i = 4; i < 64; i++) rom[i] = 32'ha0000000 + 32'(i);

    // Straight line into the halt word, then resume from HALTED.
    instr_ready = 1'b1;
    do_reset();
    push(32'h0); push(32'h4); push(32'h8);
    step(1);
    chk("first_valid", instr_valid, 32'd1);
    chk("first_pc", instr_pc, 32'h0);
    step(3);
    chk("line_count", fetch_count, 32'd3);
    chk("halt_set", halted, 32'd1);
    chk("halt_valid", instr_valid, 32'd0);
    chk("halt_addr", imem_addr, 32'hc);
    step(2);
    chk("halt_stay", halted, 32'd1);
    chk("halt_stay_valid", instr_valid, 32'd0);
    push(32'h0); push(32'h4); push(32'h8);
    redirect(32'h0);
    chk("resume_halted", halted, 32'd0);
    chk("resume_bubble", instr_valid, 32'd0);
    step(1);
    chk("resume_valid", instr_valid, 32'd1);
    chk("resume_pc", instr_pc, 32'h0);
    step(3);
    chk("rehalt", halted, 32'd1);
    chk("rehalt_count", fetch_count, 32'd6);

    // Backpressure, redirect with a simultaneous handshake, run off the ROM end.
    rom[3] = 32'h00000293;
    instr_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("bp_valid", instr_valid, 32'd1);
      chk("bp_instr", instr, 32'h00c00513);
      chk("bp_addr", imem_addr, 32'h4);
    end
    push(32'h0);
    instr_ready = 1'b1;
    step(1);
    chk("bp_release_pc", instr_pc, 32'h4);
    push(32'h4);
    redirect(32'hc);
    chk("redir_bubble", instr_valid, 32'd0);
    chk("redir_count", fetch_count, 32'd2);
    chk("redir_addr", imem_addr, 32'hc);
    for (int i = 3; i < 64; i++) push(32'(i * 4));
    step(1);
    chk("redir_target_pc", instr_pc, 32'hc);
    chk("redir_target_pc4", instr_pc4, 32'h10);
    n = 0;
    while (!fault && n < 100) begin
      step(1);
      n++;
    end
    chk("soft_fault", fault, 32'd1);
    chk("soft_valid", instr_valid, 32'd0);
    chk("soft_halted", halted, 32'd0);
    chk("soft_count", fetch_count, 32'd63);
    instr_ready = 1'b0;
    redirect(32'h0);
    chk("soft_clear", fault, 32'd0);
    step(1);
    chk("soft_resume_valid", instr_valid, 32'd1);
    chk("soft_resume_pc", instr_pc, 32'h0);
    redirect(32'h6);
    chk("hard_fault", fault, 32'd1);
    chk("hard_valid", instr_valid, 32'd0);
    redirect(32'h0);
    step(1);
    chk("hard_sticky", fault, 32'd1);
    chk("hard_sticky_valid", instr_valid, 32'd0);

    // Reset clears the hard fault; then reset mid-cycle while an instruction is valid.
    do_reset();
    step(1);
    chk("pre_async_valid", instr_valid, 32'd1);
    #2;
    do_reset();
    chk("queue_drained", 32'(q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
